// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if
// Signals between the keypad scanner, the 4x3 key matrix and the consumer of
// decoded keys.
//   row_n      [3:0]  matrix row drive, active-low, one row low at a time
//   col_n      [2:0]  matrix column sense, active-low, asynchronous to clock
//   keypad     [9:0]  one-hot digit, bit d = digit d held
//   startn            active-low, start key held
//   stopn             active-low, stop key held
//   key_strobe        one-cycle pulse on each accepted press
// master = scanner side, slave = matrix / consumer side.
// ---------------------------------------------------------------------------
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       key_strobe;

    modport master (
        output row_n,
        output keypad,
        output startn,
        output stopn,
        output key_strobe,
        input  col_n
    );

    modport slave (
        input  row_n,
        input  keypad,
        input  startn,
        input  stopn,
        input  key_strobe,
        output col_n
    );
endinterface

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x3 key matrix (1 2 3 / 4 5 6 / 7 8 9 / start 0 stop), rejects
// ghosting when several keys are down, debounces presses and releases over
// whole scan frames and presents the held key on registered outputs.
// Ports:
//   clock   system clock, all state on the rising edge
//   clearn  asynchronous active-low reset
//   bus     keypad_scanner_if.master (row_n, col_n, keypad, startn, stopn,
//           key_strobe)
// Parameters:
//   SCAN_DIV  clock cycles per row slot (3..255)
//   DEBOUNCE  matching frames needed to accept a press or release (1..15)
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input logic             clock,
    input logic             clearn,
    keypad_scanner_if.master bus
);

    typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;

    typedef struct packed {
        logic [9:0] keypad;
        logic       startn;
        logic       stopn;
    } out_t;

    localparam out_t       OUT_IDLE   = '{keypad: 10'd0, startn: 1'b1, stopn: 1'b1};
    localparam logic [3:0] CODE_START = 4'd10;
    localparam logic [3:0] CODE_STOP  = 4'd11;
    localparam logic [7:0] DIV_LAST   = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DEB        = 4'(DEBOUNCE);

    // Matrix position k = row*3 + col to key code (0..9 digits, 10 start, 11 stop).
    function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
        case (idx)
            4'd9:    return CODE_START;
            4'd10:   return 4'd0;
            4'd11:   return CODE_STOP;
            default: return idx + 4'd1;
        endcase
    endfunction

    function automatic out_t encode(input logic [3:0] code);
        out_t o;
        o = OUT_IDLE;
        if (code == CODE_START)     o.startn = 1'b0;
        else if (code == CODE_STOP) o.stopn  = 1'b0;
        else                        o.keypad[code] = 1'b1;
        return o;
    endfunction

    logic [2:0] col_meta;
    logic [2:0] col_sync;
    logic [7:0] div_cnt;
    logic [1:0] row;
    logic [8:0] scan_bits;      // rows 0..2 of the current frame, bit = row*3+col
    logic       slot_end;
    logic       frame_end;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] cand;
    out_t       outs;
    logic       key_strobe;

    cls_t       cls;
    logic [3:0] key_code;

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (row == 2'd3);

    // Columns are asynchronous to clock; the idle (released) value is all ones.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            col_meta <= 3'b111;
            col_sync <= 3'b111;
        end else begin
            col_meta <= bus.col_n;
            col_sync <= col_meta;
        end
    end

    // Row slot timing; columns are captured only on the last cycle of a slot,
    // which leaves the synchronizer time to settle after the row changes.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            div_cnt   <= '0;
            row       <= '0;
            scan_bits <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            row     <= row + 2'd1;
            case (row)
                2'd0:    scan_bits[2:0] <= ~col_sync;
                2'd1:    scan_bits[5:3] <= ~col_sync;
                2'd2:    scan_bits[8:6] <= ~col_sync;
                default: ;
            endcase
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign bus.row_n = ~(4'b0001 << row);

    // Frame classification; row 3 is taken live on the frame-end cycle.
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        logic [11:0] frame_keys;
        logic [3:0]  hits;
        logic [3:0]  idx;
        frame_keys = {~col_sync, scan_bits};
        hits       = '0;
        idx        = '0;
        for (int k = 0; k < 12; k++) begin
            if (frame_keys[k]) begin
                hits = hits + 4'd1;
                idx  = 4'(k);
            end
        end
        key_code = idx_to_code(idx);
        if (hits == 4'd0)      cls = CLS_NONE;
        else if (hits == 4'd1) cls = CLS_SINGLE;
        else                   cls = CLS_MULTI;
    end

    // Debounce FSM, evaluated once per frame end; outputs follow the state
    // registered on the same edge so they appear the cycle after the decision.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state      <= IDLE;
            cnt        <= '0;
            cand       <= '0;
            outs       <= OUT_IDLE;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (cls == CLS_SINGLE) begin
                            cand <= key_code;
                            cnt  <= 4'd1;
                            if (DEB == 4'd1) begin
                                state      <= PRESSED;
                                outs       <= encode(key_code);
                                key_strobe <= 1'b1;
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (cls == CLS_SINGLE && key_code == cand) begin
                            cnt <= cnt + 4'd1;
                            if (cnt + 4'd1 >= DEB) begin
                                state      <= PRESSED;
                                outs       <= encode(cand);
                                key_strobe <= 1'b1;
                            end
                        end else if (cls == CLS_SINGLE) begin
                            cand <= key_code;
                            cnt  <= 4'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!(cls == CLS_SINGLE && key_code == cand)) begin
                            if (DEB == 4'd1) begin
                                state <= IDLE;
                                cnt   <= '0;
                                outs  <= OUT_IDLE;
                            end else begin
                                state <= RELEASE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    RELEASE: begin
                        if (cls == CLS_NONE) begin
                            if (cnt + 4'd1 >= DEB) begin
                                state <= IDLE;
                                cnt   <= '0;
                                outs  <= OUT_IDLE;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else if (cls == CLS_SINGLE && key_code == cand) begin
                            // Key came back before release was confirmed: no new strobe.
                            state <= PRESSED;
                            cnt   <= '0;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        outs  <= OUT_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.keypad     = outs.keypad;
    assign bus.startn     = outs.startn;
    assign bus.stopn      = outs.stopn;
    assign bus.key_strobe = key_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Self-checking bench for keypad_scanner. A behavioural key matrix drives
// col_n from row_n and the set of held keys. Each stimulus step that should
// change the outputs pushes the expected output word and the clock edge at
// which it must appear; a negedge monitor pops and compares whenever the
// outputs change or key_strobe fires.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int LAT      = DEBOUNCE * FRAME;
    localparam int K_IDLE   = -1;
    localparam int K_START  = 10;
    localparam int K_STOP   = 11;

    typedef struct {
        string       tag;
        logic [12:0] outs;      // {keypad, startn, stopn, key_strobe}
        int          edge_at;
    } ev_t;

    logic        clock  = 1'b0;
    logic        clearn = 1'b0;
    logic [11:0] held   = '0;   // bit row*3+col = key physically down
    logic [2:0]  col_model;
    logic [12:0] obs_now;
    logic [11:0] prev_out;
    int          edges;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en   = 1'b0;
    ev_t         sb[$];

    keypad_scanner_if bus ();

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock  (clock),
        .clearn (clearn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    always_comb begin
        col_model = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (held[r*3 + c] && !bus.row_n[r]) col_model[c] = 1'b0;
    end
    assign bus.col_n = col_model;

    assign obs_now = {bus.keypad, bus.startn, bus.stopn, bus.key_strobe};

    // Rising edges since the last reset release.
    always @(posedge clock or negedge clearn) begin
        if (!clearn) edges <= 0;
        else         edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    function automatic logic [12:0] expect_out(input int code, input bit strobe);
        logic [9:0] kp;
        logic       s;
        logic       p;
        kp = '0;
        s  = 1'b1;
        p  = 1'b1;
        if (code >= 0 && code <= 9) kp[code] = 1'b1;
        else if (code == K_START)   s = 1'b0;
        else if (code == K_STOP)    p = 1'b0;
        return {kp, s, p, strobe};
    endfunction

    function automatic int key_bit(input int code);
        case (code)
            0:       return 10;
            K_START: return 9;
            K_STOP:  return 11;
            default: return code - 1;
        endcase
    endfunction

    task automatic push_ev(input string tag, input logic [12:0] outs, input int at);
        ev_t e;
        e.tag     = tag;
        e.outs    = outs;
        e.edge_at = at;
        sb.push_back(e);
    endtask

    task automatic score_event();
        ev_t e;
        check("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_out"}, 32'(obs_now), 32'(e.outs));
            check({e.tag, "_edge"}, edges, e.edge_at);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en && (obs_now[12:1] != prev_out || obs_now[0])) score_event();
        prev_out <= obs_now[12:1];
    end

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clock);
    endtask

    // Key goes down at a frame boundary; accepted DEBOUNCE frames later.
    task automatic press_key(input string tag, input int code);
        held[key_bit(code)] = 1'b1;
        push_ev(tag, expect_out(code, 1'b1), edges + LAT);
    endtask

    task automatic release_keys(input string tag, input bit expect_idle);
        held = '0;
        if (expect_idle) push_ev(tag, expect_out(K_IDLE, 1'b0), edges + LAT);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_n"},  32'(bus.row_n),      32'h0000_000e);
        check({tag, "_keypad"}, 32'(bus.keypad),     32'h0);
        check({tag, "_startn"}, 32'(bus.startn),     32'h1);
        check({tag, "_stopn"},  32'(bus.stopn),      32'h1);
        check({tag, "_strobe"}, 32'(bus.key_strobe), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", edges);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_row;

        // Reset state
        clearn = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        clearn = 1'b1;
        mon_en = 1'b1;

        // Idle scan: rows rotate every SCAN_DIV cycles, no key activity
        for (int s = 0; s < 40; s++) begin
            exp_row = ~(4'b0001 << (s % 4));
            check("idle_row_n", 32'(bus.row_n), 32'(exp_row));
            repeat (SCAN_DIV) @(negedge clock);
        end
        check("idle_out", 32'(obs_now), 32'(expect_out(K_IDLE, 1'b0)));

        // Key 2 held for 6 frames then released
        press_key("k2_press", 2);
        wait_frames(6);
        release_keys("k2_release", 1'b1);
        wait_frames(4);

        // Start key, then 5 and 9 in sequence
        press_key("start_press", K_START);
        wait_frames(5);
        release_keys("start_release", 1'b1);
        wait_frames(4);
        press_key("k5_press", 5);
        wait_frames(4);
        release_keys("k5_release", 1'b1);
        wait_frames(4);
        press_key("k9_press", 9);
        wait_frames(4);
        release_keys("k9_release", 1'b1);
        wait_frames(4);

        // Stop key
        press_key("stop_press", K_STOP);
        wait_frames(4);
        release_keys("stop_release", 1'b1);
        wait_frames(4);

        // Key 5 bouncing per frame, then stable
        for (int f = 0; f < 6; f++) begin
            held[key_bit(5)] = (f % 2 == 0);
            wait_frames(1);
        end
        press_key("k5_bounce_press", 5);
        wait_frames(4);
        release_keys("k5_bounce_release", 1'b1);
        wait_frames(4);

        // Ghosting: 1 and 9 together from idle never produce output
        held[key_bit(1)] = 1'b1;
        held[key_bit(9)] = 1'b1;
        wait_frames(4);
        release_keys("multi_idle", 1'b0);
        wait_frames(2);

        // Pressed 1, then 9 added: 1 held until release count completes
        press_key("k1_press", 1);
        wait_frames(4);
        held[key_bit(9)] = 1'b1;
        wait_frames(3);
        release_keys("k1_multi_release", 1'b1);
        wait_frames(4);

        // Short gap in a held key returns to PRESSED without a second strobe
        press_key("k8_press", 8);
        wait_frames(4);
        held = '0;
        wait_frames(1);
        held[key_bit(8)] = 1'b1;
        wait_frames(3);
        release_keys("k8_release", 1'b1);
        wait_frames(4);

        // Reset mid-press, key 9 still held through reset
        press_key("k9_pre_reset", 9);
        wait_frames(4);
        check("k9_held", 32'(obs_now), 32'(expect_out(9, 1'b0)));
        #2;
        mon_en = 1'b0;
        clearn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clock);
        clearn = 1'b1;
        mon_en = 1'b1;
        push_ev("k9_rearm", expect_out(9, 1'b1), edges + LAT);
        wait_frames(4);
        release_keys("k9_final_release", 1'b1);
        wait_frames(4);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, clock cycles per row slot (legal 3..255).
REQ-002 SHALL have parameter DEBOUNCE, default 3, consecutive matching scan frames to accept a press or release (legal 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: `clock  input  1  system clock, all state on rising edge`.
REQ-004 SHALL have `clearn  input  1  asynchronous active-low reset`.
REQ-005 SHALL have `row_n  output  4  matrix row drive, active-low, exactly one row low`.
REQ-006 SHALL have `col_n  input  3  matrix column sense, active-low, asynchronous`.
REQ-007 SHALL have `keypad  output  10  one-hot digit, bit d = digit d held`.
REQ-008 SHALL have `startn  output  1  active-low, start key held`.
REQ-009 SHALL have `stopn  output  1  active-low, stop key held`.
REQ-010 SHALL have `key_strobe  output  1  one-cycle pulse on each accepted press`.

Function
REQ-011 SHALL use the key map row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = start,0,stop, with columns 0,1,2 left to right.
REQ-012 SHALL pass col_n through a 2-flop synchronizer before any use.
REQ-013 SHALL drive each row low for SCAN_DIV cycles, in the order 0,1,2,3,0,…; one frame = 4*SCAN_DIV cycles.
REQ-014 SHALL sample the synchronized columns on the last cycle of each row slot only.
REQ-015 SHALL classify each frame, at its final cycle, as NONE (no low column), SINGLE(k) (exactly one key), or MULTI (two or more keys, ghost rejection).
REQ-016 SHALL implement the FSM states IDLE, CONFIRM, PRESSED, RELEASE, with counter cnt (4 bits) and candidate key cand, evaluated once per frame end.
REQ-017 In IDLE: SINGLE(k) SHALL set cand=k, cnt=1 and go to CONFIRM (or go straight to PRESSED if DEBOUNCE=1); NONE or MULTI SHALL stay in IDLE.
REQ-018 In CONFIRM: SINGLE(cand) SHALL increment cnt; reaching DEBOUNCE SHALL go to PRESSED; SINGLE(other) SHALL set cand=other, cnt=1; NONE or MULTI SHALL go to IDLE.
REQ-019 In PRESSED: SINGLE(cand) SHALL stay; NONE, MULTI or another key SHALL go to RELEASE with cnt=1 (or go to IDLE directly if DEBOUNCE=1).
REQ-020 In RELEASE: NONE SHALL increment cnt, and reaching DEBOUNCE SHALL go to IDLE; SINGLE(cand) SHALL return to PRESSED; MULTI or another key SHALL hold RELEASE with cnt=0.
REQ-021 SHALL hold the outputs for cand through PRESSED and RELEASE; outputs SHALL be inactive in IDLE and CONFIRM.
REQ-022 Outputs SHALL be registered and update on the cycle after the deciding frame-end cycle.
REQ-023 SHALL assert key_strobe for exactly one cycle on each CONFIRM/IDLE->PRESSED transition, and SHALL NOT assert it on RELEASE->PRESSED.
REQ-024 Output encoding: for digit cand, keypad has only bit cand set and startn=stopn=1; for start, keypad=0 and startn=0; for stop, keypad=0 and stopn=0.
REQ-025 SHALL never assert more than one of {any keypad bit, !startn, !stopn} at a time.
REQ-026 Default press latency, with a key stable before a frame start: outputs assert 3 frames (48 cycles) plus 1 cycle after that frame start.

Reset
REQ-027 While clearn=0, SHALL hold row_n=4'b1110, keypad=0, startn=1, stopn=1, key_strobe=0, state IDLE, and cnt, slot counter and synchronizers cleared.
REQ-028 Reset asserted mid-press SHALL clear outputs immediately; after release of reset, the held key SHALL require a full DEBOUNCE-frame confirmation again.

Verification
REQ-029 Reset then idle, col_n=3'b111 for 10 frames -> row_n cycles 1110,1101,1011,0111 every 4 cycles; keypad=0, startn=stopn=1, no key_strobe.
REQ-030 Hold key 2 (col1 low while row0 low) for 6 frames, then release -> keypad=10'b0000000100 asserted after 3 frames with one key_strobe; cleared 3 frames after release.
REQ-031 Hold the start key (row3/col0) for 5 frames -> startn=0, keypad=0, stopn=1; then press 5 and 9 in sequence -> each produces its own single key_strobe.
REQ-032 Key 5 bounces (present/absent alternating per frame) for 6 frames, then stable for 3 frames -> no output during bounce; keypad bit 5 set only after the 3 stable frames.
REQ-033 Keys 1 and 9 held together -> MULTI, outputs stay inactive; in PRESSED(1), adding key 9 -> key 1 stays held until the release count completes.
REQ-034 Assert clearn=0 while keypad=bit 9 -> outputs clear asynchronously; after reset release with key 9 still held, re-assertion occurs after 3 frames.
